// File: rtl/aes_pkg.sv
// aes_pkg: types and constants shared by the AES storage path.
//   page_asm_state_t : page_assembler FSM encoding
//   BLOCK_BYTES      : bytes in one 128-bit AES block
//   PAGE_BYTES       : bytes in a default page
//   scu_mode_t       : storage control unit mode, shared with the control unit
package aes_pkg;

  localparam int BLOCK_BYTES     = 16;
  localparam int NUM_BLOCKS_DFLT = 256;
  localparam int PAGE_BYTES      = NUM_BLOCKS_DFLT * BLOCK_BYTES;

  typedef enum logic [2:0] {
    PA_IDLE  = 3'd0,
    PA_FILL  = 3'd1,
    PA_DRAIN = 3'd2,
    PA_CHK   = 3'd3,
    PA_DONE  = 3'd4
  } page_asm_state_t;

  typedef enum logic [1:0] {
    SCU_IDLE    = 2'b00,
    SCU_ENCRYPT = 2'b10,
    SCU_DECRYPT = 2'b11
  } scu_mode_t;

endpackage

// File: rtl/flex_counter.sv
// flex_counter: up-counter that saturates at rollover_val.
//   clk, n_rst    : clock, synchronous active-low reset
//   clear         : synchronous clear to 0 (wins over count_enable)
//   count_enable  : advance by one unless already at rollover_val
//   rollover_val  : terminal / saturation value
//   count_out     : current count
//   rollover_flag : count_out == rollover_val
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (count_enable && (count_q != rollover_val))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_out     = count_q;
  assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/page_assembler.sv
// page_assembler: collects NUM_BLOCKS AES result blocks into a page buffer,
// then streams the page out OUT_W bits at a time over valid/ready.
//   clk, n_rst           : clock, synchronous active-low reset
//   start                : abort any page, clear, begin filling
//   res_valid, res_data  : AES result block strobe and data
//   fill_ready           : accepting blocks
//   blocks_filled        : blocks captured, 0..NUM_BLOCKS
//   page_full            : page captured, not yet finished
//   out_data, out_valid  : output byte stream
//   out_ready            : downstream accept
//   done                 : one-cycle pulse after last byte accepted
//   overflow             : sticky, block arrived when not filling
// Optional: PAGE_CHECKSUM_EN appends an XOR checksum byte after the page.
//
// state | meaning
// IDLE  | waiting for start
// FILL  | capturing blocks into the buffer
// DRAIN | streaming buffer bytes, block 0 first, LSB byte first
// CHK   | presenting the XOR checksum byte (PAGE_CHECKSUM_EN only)
// DONE  | one-cycle done pulse, back to IDLE
module page_assembler
  import aes_pkg::*;
#(
  parameter int BLOCK_W    = 128,
  parameter int NUM_BLOCKS = NUM_BLOCKS_DFLT,
  parameter int OUT_W      = 8
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            start,
  input  logic                            res_valid,
  input  logic [BLOCK_W-1:0]              res_data,
  output logic                            fill_ready,
  output logic [$clog2(NUM_BLOCKS+1)-1:0] blocks_filled,
  output logic                            page_full,
  output logic [OUT_W-1:0]                out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            done,
  output logic                            overflow
);

  localparam int BPB    = BLOCK_W / OUT_W;
  localparam int PG_B   = NUM_BLOCKS * BPB;
  localparam int BIDX_W = $clog2(PG_B);
  localparam int BLK_W  = $clog2(NUM_BLOCKS);
  localparam int SEL_W  = $clog2(BPB);
  localparam int CNT_W  = $clog2(NUM_BLOCKS + 1);

  page_asm_state_t state_q, state_d;
  logic [BIDX_W-1:0] byte_idx_q, byte_idx_d;
  logic              overflow_q, overflow_d;
  logic [BLOCK_W-1:0] page_mem [NUM_BLOCKS];

  logic wr_en, blk_full, blk_last, byte_last, drain_hs, cnt_clear;
  logic [BLK_W-1:0]   rd_blk;
  logic [SEL_W-1:0]   rd_sel;
  logic [BLOCK_W-1:0] rd_word;
  logic [OUT_W-1:0]   rd_byte;

`ifdef PAGE_CHECKSUM_EN
  logic [OUT_W-1:0] csum_q, csum_d;
`endif

  // start wins over a same-cycle res_valid: the block is neither stored nor counted
  assign wr_en     = (state_q == PA_FILL) && res_valid && !start && !blk_full;
  assign blk_last  = (blocks_filled == CNT_W'(NUM_BLOCKS - 1));
  assign byte_last = (byte_idx_q == BIDX_W'(PG_B - 1));
  assign drain_hs  = (state_q == PA_DRAIN) && out_ready;
  assign cnt_clear = start || (state_q == PA_DONE);

  flex_counter #(.NUM_CNT_BITS(CNT_W)) u_blk_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear),
    .count_enable (wr_en),
    .rollover_val (CNT_W'(NUM_BLOCKS)),
    .count_out    (blocks_filled),
    .rollover_flag(blk_full)
  );

  always_ff @(posedge clk) begin
    if (wr_en) page_mem[blocks_filled[BLK_W-1:0]] <= res_data;
  end

  assign rd_blk  = BLK_W'(byte_idx_q / BPB);
  assign rd_sel  = SEL_W'(byte_idx_q % BPB);
  assign rd_word = page_mem[rd_blk];
  assign rd_byte = rd_word[rd_sel*OUT_W +: OUT_W];

  // state register
  always_ff @(posedge clk) begin
    if (!n_rst) state_q <= PA_IDLE;
    else        state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = PA_FILL;
    end else begin
      case (state_q)
        PA_IDLE:  state_d = PA_IDLE;
        PA_FILL:  if (wr_en && blk_last) state_d = PA_DRAIN;
`ifdef PAGE_CHECKSUM_EN
        PA_DRAIN: if (drain_hs && byte_last) state_d = PA_CHK;
        PA_CHK:   if (out_ready) state_d = PA_DONE;
`else
        PA_DRAIN: if (drain_hs && byte_last) state_d = PA_DONE;
`endif
        PA_DONE:  state_d = PA_IDLE;
        default:  state_d = PA_IDLE;
      endcase
    end
  end

  // outputs
  always_comb begin
    fill_ready = (state_q == PA_FILL);
    page_full  = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    done       = (state_q == PA_DONE);
    case (state_q)
      PA_DRAIN: begin
        page_full = 1'b1;
        out_valid = 1'b1;
        out_data  = rd_byte;
      end
`ifdef PAGE_CHECKSUM_EN
      PA_CHK: begin
        page_full = 1'b1;
        out_valid = 1'b1;
        out_data  = csum_q;
      end
`endif
      PA_DONE: page_full = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    byte_idx_d = byte_idx_q;
    overflow_d = overflow_q;
`ifdef PAGE_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    if (start) begin
      byte_idx_d = '0;
      overflow_d = 1'b0;
`ifdef PAGE_CHECKSUM_EN
      csum_d     = '0;
`endif
    end else begin
      if (res_valid && (state_q != PA_FILL)) overflow_d = 1'b1;
      if (drain_hs) begin
        byte_idx_d = byte_last ? '0 : byte_idx_q + 1'b1;
`ifdef PAGE_CHECKSUM_EN
        csum_d     = csum_q ^ rd_byte;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      byte_idx_q <= '0;
      overflow_q <= 1'b0;
`ifdef PAGE_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      byte_idx_q <= byte_idx_d;
      overflow_q <= overflow_d;
`ifdef PAGE_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign overflow = overflow_q;

endmodule
